// File: rtl/touch_pio_irq_in.sv
// Avalon-MM input PIO for panel interrupt lines: per-bit synchroniser, glitch filter,
// rise/fall edge capture with write-1-to-clear, and a level/edge selectable IRQ.
module touch_pio_irq_in #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DB_W        = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   typedef enum logic [2:0] {
      A_DATA = 3'd0, A_RISE = 3'd1, A_MASK = 3'd2, A_CAP  = 3'd3,
      A_FALL = 3'd4, A_THR  = 3'd5, A_MODE = 3'd6, A_RSVD = 3'd7
   } reg_addr_e;

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [DB_W-1:0]  cnt    [WIDTH];
   logic [WIDTH-1:0] s, filt, filt_d;
   logic [WIDTH-1:0] rise_en, fall_en, irq_mask, edge_cap;
   logic [WIDTH-1:0] set_bits, clr_bits;
   logic [DB_W-1:0]  db_thr;
   logic             irq_mode;
   logic             wr_en;
   logic [31:0]      rd_mux;
   logic             unused_wdata;

   assign s     = sync_q[SYNC_STAGES-1];
   assign wr_en = chipselect & ~write_n;

   // Writedata bits beyond each register's width are ignored by design.
   assign unused_wdata = ^writedata;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   // NOTE: the synchroniser and filter arrays are reset too, so no stale count or edge survives reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // Glitch filter: a change must persist T+1 cycles at s before filt follows it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         filt   <= '0;
         filt_d <= '0;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         filt_d <= filt;
         for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == filt[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] >= db_thr) begin
               filt[i] <= s[i];
               cnt[i]  <= '0;
            end else begin
               cnt[i] <= cnt[i] + DB_W'(1);
            end
         end
      end
   end

   assign set_bits = (filt & ~filt_d & rise_en) | (~filt & filt_d & fall_en);
   assign clr_bits = (wr_en && address == A_CAP) ? writedata[WIDTH-1:0] : '0;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rise_en  <= '0;
         fall_en  <= '0;
         irq_mask <= '0;
         edge_cap <= '0;
         db_thr   <= '0;
         irq_mode <= 1'b0;
      end else begin
         // Set is OR-ed after the clear so a coincident edge is never lost.
         edge_cap <= (edge_cap & ~clr_bits) | set_bits;
         if (wr_en) begin
            case (reg_addr_e'(address))
               A_RISE:  rise_en  <= writedata[WIDTH-1:0];
               A_MASK:  irq_mask <= writedata[WIDTH-1:0];
               A_FALL:  fall_en  <= writedata[WIDTH-1:0];
               A_THR:   db_thr   <= writedata[DB_W-1:0];
               A_MODE:  irq_mode <= writedata[0];
               default: ;
            endcase
         end
      end
   end

   // NOTE: assigning a default first keeps this combinational block from inferring a latch.
   always_comb begin
      rd_mux = '0;
      case (reg_addr_e'(address))
         A_DATA:  rd_mux[WIDTH-1:0] = filt;
         A_RISE:  rd_mux[WIDTH-1:0] = rise_en;
         A_MASK:  rd_mux[WIDTH-1:0] = irq_mask;
         A_CAP:   rd_mux[WIDTH-1:0] = edge_cap;
         A_FALL:  rd_mux[WIDTH-1:0] = fall_en;
         A_THR:   rd_mux[DB_W-1:0]  = db_thr;
         A_MODE:  rd_mux[0]         = irq_mode;
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) readdata <= '0;
      else          readdata <= rd_mux;
   end

   assign irq = |((irq_mode ? edge_cap : filt) & irq_mask);

endmodule

// File: tb/tb_touch_pio_irq_in.sv
// Scoreboarded bench for touch_pio_irq_in: a run-length reference model predicts readdata
// and irq every cycle; a negedge monitor compares them against the DUT.
module tb_touch_pio_irq_in;

   localparam int W   = 8;
   localparam int S   = 2;
   localparam int DBW = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [2:0]    address = '0;
   logic          chipselect = 1'b0;
   logic          write_n = 1'b1;
   logic [31:0]   writedata = '0;
   logic [W-1:0]  in_port = '0;
   logic [31:0]   readdata;
   logic          irq;

   int checks = 0;
   int errors = 0;

   touch_pio_irq_in #(.WIDTH(W), .SYNC_STAGES(S), .DB_W(DBW)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rd;
      logic        irq;
   } exp_t;
   exp_t sb[$];

   // Reference model: in_port history queue, per-bit disagreement run lengths.
   logic [W-1:0] hist[$];
   logic [W-1:0] m_filt, m_prev, m_rise, m_fall, m_mask, m_cap;
   int           m_run[W];
   int           m_thr;
   logic         m_mode;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      exp_t        e;
      logic [W-1:0] s, set_b, clr_b, old_filt;
      if (!reset_n) begin
         hist.delete();
         for (int i = 0; i < S; i++) hist.push_back('0);
         m_filt = '0; m_prev = '0; m_rise = '0; m_fall = '0; m_mask = '0; m_cap = '0;
         m_thr = 0; m_mode = 1'b0;
         for (int i = 0; i < W; i++) m_run[i] = 0;
         e.rd = '0;
      end else begin
         case (address)
            3'd0: e.rd = {24'b0, m_filt};
            3'd1: e.rd = {24'b0, m_rise};
            3'd2: e.rd = {24'b0, m_mask};
            3'd3: e.rd = {24'b0, m_cap};
            3'd4: e.rd = {24'b0, m_fall};
            3'd5: e.rd = 32'(m_thr);
            3'd6: e.rd = {31'b0, m_mode};
            default: e.rd = '0;
         endcase
         s     = hist.pop_front();
         hist.push_back(in_port);
         set_b = (m_filt & ~m_prev & m_rise) | (~m_filt & m_prev & m_fall);
         clr_b = (chipselect && !write_n && address == 3'd3) ? writedata[W-1:0] : '0;
         old_filt = m_filt;
         for (int i = 0; i < W; i++) begin
            if (s[i] == m_filt[i]) m_run[i] = 0;
            else if (m_run[i] >= m_thr) begin m_filt[i] = s[i]; m_run[i] = 0; end
            else m_run[i]++;
         end
         m_prev = old_filt;
         m_cap  = (m_cap & ~clr_b) | set_b;
         if (chipselect && !write_n) begin
            case (address)
               3'd1: m_rise = writedata[W-1:0];
               3'd2: m_mask = writedata[W-1:0];
               3'd4: m_fall = writedata[W-1:0];
               3'd5: m_thr  = int'(writedata[DBW-1:0]);
               3'd6: m_mode = writedata[0];
               default: ;
            endcase
         end
      end
      e.irq = |((m_mode ? m_cap : m_filt) & m_mask);
      sb.push_back(e);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("readdata", readdata, e.rd);
         check("irq", {31'b0, irq}, {31'b0, e.irq});
      end
   end

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd_expect(input string name, input logic [2:0] a, input logic [31:0] exp);
      @(negedge clk);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      @(posedge clk);
      #1;
      check(name, readdata, exp);
      chipselect = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Inputs high during and after reset: no capture since enables are 0.
      in_port = 8'hFF;
      idle(5);
      @(negedge clk) reset_n = 1'b1;
      idle(20);
      rd_expect("data_after_reset", 3'd0, 32'hFF);
      rd_expect("cap_after_reset", 3'd3, 32'h0);
      check("irq_after_reset", {31'b0, irq}, 32'h0);

      @(negedge clk) in_port = 8'h80;
      idle(10);

      // Debounce rejects a 3-cycle pulse at T=3 and accepts a 4-cycle pulse.
      wr(3'd5, 32'd3);
      wr(3'd1, 32'h01);
      wr(3'd6, 32'h1);
      wr(3'd2, 32'h01);
      @(negedge clk) in_port[0] = 1'b1;
      idle(3);
      in_port[0] = 1'b0;
      idle(12);
      rd_expect("cap_short_pulse", 3'd3, 32'h0);
      @(negedge clk) in_port[0] = 1'b1;
      idle(4);
      in_port[0] = 1'b0;
      idle(12);
      rd_expect("cap_long_pulse", 3'd3, 32'h01);
      check("irq_long_pulse", {31'b0, irq}, 32'h1);
      wr(3'd3, 32'h01);
      idle(2);

      // Falling-edge capture and selective W1C.
      wr(3'd2, 32'h81);
      wr(3'd4, 32'h80);
      @(negedge clk) in_port[7] = 1'b0;
      idle(10);
      rd_expect("cap_fall", 3'd3, 32'h80);
      wr(3'd3, 32'h01);
      rd_expect("cap_w1c_other", 3'd3, 32'h80);
      wr(3'd3, 32'h80);
      rd_expect("cap_w1c_bit7", 3'd3, 32'h0);

      // W1C in the very cycle bit2's edge is captured: the set wins.
      wr(3'd1, 32'h04);
      @(negedge clk) in_port[2] = 1'b1;
      repeat (S + 3 + 1) @(posedge clk);
      wr(3'd3, 32'h04);
      rd_expect("cap_set_beats_clr", 3'd3, 32'h04);
      wr(3'd3, 32'hFF);

      // Level mode on bit2.
      wr(3'd6, 32'h0);
      wr(3'd2, 32'h04);
      idle(2);
      check("irq_level_high", {31'b0, irq}, 32'h1);
      @(negedge clk) in_port[2] = 1'b0;
      idle(S + 3 + 2);
      check("irq_level_low", {31'b0, irq}, 32'h0);

      // Reset mid-count discards everything.
      wr(3'd1, 32'h01);
      wr(3'd6, 32'h1);
      @(negedge clk) in_port[0] = 1'b1;
      idle(S + 2);
      reset_n = 1'b0;
      in_port = '0;
      idle(2);
      reset_n = 1'b1;
      idle(10);
      for (int a = 0; a < 8; a++) rd_expect("reg_after_mid_reset", 3'(a), 32'h0);

      // Randomised traffic against the reference model.
      for (int it = 0; it < 1500; it++) begin
         int act;
         act = $urandom_range(0, 9);
         if (act <= 3) begin
            @(negedge clk) in_port = in_port ^ W'($urandom_range(0, 255));
            idle($urandom_range(0, 8));
         end else if (act <= 6) begin
            logic [2:0] a;
            a = 3'($urandom_range(0, 7));
            if (a == 3'd5) wr(a, 32'($urandom_range(0, 4)));
            else           wr(a, $urandom);
         end else begin
            @(negedge clk);
            address = 3'($urandom_range(0, 7)); chipselect = 1'b1; write_n = 1'b1;
            @(negedge clk) chipselect = 1'b0;
         end
      end

      idle(4);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
